// File: rtl/minmax_window_seq_pkg.sv
// rtl/minmax_window_seq_pkg.sv - shared encodings and constants for the min/max window sequencer
package minmax_window_seq_pkg;

   localparam int MSB_DEF  = 31;
   localparam int CNTW_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CLR  = 2'd1,
      ST_RUN  = 2'd2
   } seq_state_t;

   // Values the datapath loads into its min and max registers on clear.
   localparam logic [MSB_DEF:0] DP_ALL_ONES = '1;
   localparam logic [MSB_DEF:0] DP_ZERO     = '0;

endpackage

// File: rtl/minmax_result_buf.sv
// rtl/minmax_result_buf.sv - one-deep valid/ready holding register for window results
module minmax_result_buf
   import minmax_window_seq_pkg::*;
#(
   parameter int MSB  = MSB_DEF,
   parameter int CNTW = CNTW_DEF
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            fill,
   input  logic [MSB:0]    fill_data,
   input  logic [CNTW-1:0] fill_index,
   input  logic            r_ready,
   output logic            r_valid,
   output logic [MSB:0]    r_data,
   output logic [CNTW-1:0] r_index
);

   // A fill always wins, so a drain and a refill in one cycle leaves the buffer full.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_index <= '0;
      end else if (fill) begin
         r_valid <= 1'b1;
         r_data  <= fill_data;
         r_index <= fill_index;
      end else if (r_ready) begin
         r_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/minmax_window_seq.sv
// rtl/minmax_window_seq.sv - windowed sequencer driving the min/max/average datapath
module minmax_window_seq
   import minmax_window_seq_pkg::*;
#(
   parameter int MSB  = MSB_DEF,
   parameter int CNTW = CNTW_DEF
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            start,
   input  logic            stop,
   input  logic [CNTW-1:0] win_len,
   input  logic            s_valid,
   output logic            s_ready,
   input  logic [MSB:0]    s_data,
   output logic [MSB:0]    dp_in,
   output logic            dp_clear,
   output logic            dp_enable,
   output logic            dp_reset,
   input  logic [MSB:0]    dp_out,
   output logic            r_valid,
   input  logic            r_ready,
   output logic [MSB:0]    r_data,
   output logic [CNTW-1:0] r_index,
   output logic            busy
);

   seq_state_t      state, state_nx;
   logic [CNTW-1:0] len_q;
   logic [CNTW-1:0] count_q;
   logic [CNTW-1:0] win_q;
   logic [MSB:0]    hold_q;
   logic            first_q;
   logic            last;
   logic            accept;
   logic            fill;

   assign last     = (count_q == len_q - CNTW'(1));
   // Only the closing sample of a window waits for room in the result buffer.
   assign s_ready  = (state == ST_RUN) && !(last && r_valid && !r_ready);
   assign accept   = s_valid && s_ready;
   // A sample taken in the same cycle as stop belongs to an abandoned window.
   assign fill     = accept && last && !stop;
   assign busy     = (state != ST_IDLE);
   assign dp_reset = 1'b0;

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nx;
   end

   // Next state and datapath controls; idle RUN cycles replay the held average,
   // which lies inside [min,max] and so keeps the datapath enabled without disturbing it.
   always_comb begin
      state_nx  = state;
      dp_clear  = 1'b1;
      dp_enable = 1'b0;
      dp_in     = s_data;
      case (state)
         ST_IDLE: begin
            if (start && !stop) state_nx = ST_CLR;
         end
         ST_CLR: begin
            state_nx = stop ? ST_IDLE : ST_RUN;
         end
         ST_RUN: begin
            dp_clear = 1'b0;
            if (accept) begin
               dp_enable = 1'b1;
            end else if (!first_q) begin
               dp_enable = 1'b1;
               dp_in     = hold_q;
            end
            if (stop)      state_nx = ST_IDLE;
            else if (fill) state_nx = ST_CLR;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // Window length latch, per-window sample count, held average and window number.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         len_q   <= CNTW'(1);
         count_q <= '0;
         win_q   <= '0;
         hold_q  <= '0;
         first_q <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start && !stop) len_q <= (win_len == '0) ? CNTW'(1) : win_len;
            end
            ST_CLR: begin
               first_q <= 1'b1;
               count_q <= '0;
            end
            ST_RUN: begin
               if (accept) begin
                  hold_q  <= dp_out;
                  first_q <= 1'b0;
                  count_q <= count_q + CNTW'(1);
               end
               if (fill) win_q <= win_q + CNTW'(1);
            end
            default: ;
         endcase
      end
   end

   minmax_result_buf #(
      .MSB  (MSB),
      .CNTW (CNTW)
   ) u_result_buf (
      .clock      (clock),
      .reset_n    (reset_n),
      .fill       (fill),
      .fill_data  (dp_out),
      .fill_index (win_q),
      .r_ready    (r_ready),
      .r_valid    (r_valid),
      .r_data     (r_data),
      .r_index    (r_index)
   );

endmodule

// File: tb/tb_minmax_window_seq.sv
// tb/tb_minmax_window_seq.sv - self-checking bench for minmax_window_seq with datapath model
module tb_minmax_window_seq;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [15:0] win_len = 16'd0;
   logic        s_valid = 1'b0;
   logic [31:0] s_data = 32'd0;
   logic        r_ready = 1'b0;
   logic        s_ready, dp_clear, dp_enable, dp_reset, r_valid, busy;
   logic [31:0] dp_in, dp_out, r_data;
   logic [15:0] r_index;

   int total = 0;
   int bad = 0;

   minmax_window_seq dut (
      .clock(clock), .reset_n(reset_n), .start(start), .stop(stop), .win_len(win_len),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .dp_in(dp_in), .dp_clear(dp_clear), .dp_enable(dp_enable), .dp_reset(dp_reset),
      .dp_out(dp_out), .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
      .r_index(r_index), .busy(busy)
   );

   always #5 clock = ~clock;

   // External min/max/average datapath: dp_out reflects the current input combinationally.
   logic [31:0] dmn, dmx, nmn, nmx;
   always_comb begin
      nmn = dmn;
      nmx = dmx;
      if (dp_enable) begin
         if (dp_in < dmn) nmn = dp_in;
         if (dp_in > dmx) nmx = dp_in;
      end
      dp_out = 32'(({1'b0, nmn} + {1'b0, nmx}) >> 1);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         dmn <= '1;
         dmx <= '0;
      end else if (dp_clear || dp_reset) begin
         dmn <= '1;
         dmx <= '0;
      end else begin
         dmn <= nmn;
         dmx <= nmx;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: mode, samples of the open window, pending result, window number.
   int          ph;
   int          mlen;
   int          widx;
   logic [31:0] win_s[$];
   bit          mrv;
   logic [31:0] mrd;
   logic [15:0] mri;
   logic [31:0] got_d[$];
   logic [15:0] got_i[$];
   logic [31:0] lo, hi;
   logic [32:0] sum;
   bit          exp_rdy, acc, fill;

   always @(negedge clock) begin
      if (!reset_n) begin
         ph = 0; mlen = 1; widx = 0; win_s.delete();
         mrv = 0; mrd = '0; mri = '0;
      end else begin
         check("busy", 64'(busy), 64'(ph != 0));
         check("dp_clear", 64'(dp_clear), 64'(ph != 2));
         if (ph != 2) check("dp_enable_off", 64'(dp_enable), 64'(0));
         check("dp_reset", 64'(dp_reset), 64'(0));
         check("r_valid", 64'(r_valid), 64'(mrv));
         if (mrv) begin
            check("r_data", 64'(r_data), 64'(mrd));
            check("r_index", 64'(r_index), 64'(mri));
         end
         exp_rdy = (ph == 2) && !(win_s.size() == mlen - 1 && mrv && !r_ready);
         check("s_ready", 64'(s_ready), 64'(exp_rdy));
         if (ph == 2) begin
            lo = '1; hi = '0;
            foreach (win_s[i]) begin
               if (win_s[i] < lo) lo = win_s[i];
               if (win_s[i] > hi) hi = win_s[i];
            end
            check("dp_min", 64'(dmn), 64'(lo));
            check("dp_max", 64'(dmx), 64'(hi));
         end
         if (r_valid && r_ready) begin
            got_d.push_back(r_data);
            got_i.push_back(r_index);
         end
         acc  = s_valid && exp_rdy;
         fill = 0;
         case (ph)
            0: if (start && !stop) begin
                  ph = 1;
                  mlen = (win_len == 16'd0) ? 1 : int'(win_len);
               end
            1: begin
                  win_s.delete();
                  ph = stop ? 0 : 2;
               end
            default: begin
                  if (stop) ph = 0;
                  else if (acc) begin
                     win_s.push_back(s_data);
                     if (win_s.size() == mlen) begin
                        lo = '1; hi = '0;
                        foreach (win_s[i]) begin
                           if (win_s[i] < lo) lo = win_s[i];
                           if (win_s[i] > hi) hi = win_s[i];
                        end
                        sum  = {1'b0, lo} + {1'b0, hi};
                        fill = 1;
                        ph   = 1;
                     end
                  end
               end
         endcase
         if (fill) begin
            mrv = 1; mrd = sum[32:1]; mri = widx[15:0]; widx++;
         end else if (mrv && r_ready) begin
            mrv = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic go(input int len);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      win_len = 16'(len);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input logic [31:0] v);
      int n = 0;
      s_valid = 1'b1;
      s_data  = v;
      @(negedge clock);
      while (!s_ready && n < 100) begin
         n++;
         @(negedge clock);
      end
      if (!s_ready) begin
         total++; bad++;
         $display("FAIL send_timeout: s_ready stayed 0, required 1");
      end
      tick();
      s_valid = 1'b0;
   endtask

   task automatic expect_result(input string name, input logic [31:0] d, input logic [15:0] idx);
      int n = 0;
      while (got_d.size() == 0 && n < 50) begin
         n++;
         tick();
      end
      if (got_d.size() == 0) begin
         total++; bad++;
         $display("FAIL %s_timeout: no result, required data %0h", name, d);
      end else begin
         check({name, "_data"}, 64'(got_d.pop_front()), 64'(d));
         check({name, "_index"}, 64'(got_i.pop_front()), 64'(idx));
      end
   endtask

   initial begin
      repeat (2) @(negedge clock);
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_r_valid", 64'(r_valid), 64'(0));
      check("rst_s_ready", 64'(s_ready), 64'(0));
      check("rst_dp_clear", 64'(dp_clear), 64'(1));
      check("rst_r_data", 64'(r_data), 64'(0));
      check("rst_r_index", 64'(r_index), 64'(0));
      tick();
      reset_n = 1'b1;
      tick();

      // Back-to-back window of four.
      go(4);
      send(32'd10); send(32'd20); send(32'd30); send(32'd40);
      @(negedge clock);
      check("t1_r_valid", 64'(r_valid), 64'(1));
      check("t1_r_data", 64'(r_data), 64'(25));
      check("t1_r_index", 64'(r_index), 64'(0));
      r_ready = 1'b1;
      expect_result("t1", 32'd25, 16'd0);
      r_ready = 1'b0;

      // Gaps inside a window replay the held value.
      go(2);
      send(32'd5);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check("t2_gap_enable", 64'(dp_enable), 64'(1));
         check("t2_gap_dp_in", 64'(dp_in), 64'(5));
      end
      tick();
      send(32'd7);
      r_ready = 1'b1;
      expect_result("t2", 32'd6, 16'd1);

      // Single-sample windows and full-scale values.
      go(1);
      send(32'd100);
      expect_result("t3a", 32'd100, 16'd2);
      send(32'hFFFF_FFFF);
      expect_result("t3b", 32'hFFFF_FFFF, 16'd3);
      go(2);
      send(32'hFFFF_FFFF); send(32'hFFFF_FFFE);
      expect_result("t3c", 32'hFFFF_FFFE, 16'd4);
      r_ready = 1'b0;
      got_d.delete(); got_i.delete();

      // Full buffer stalls only the closing sample; drain and refill together.
      go(2);
      send(32'd1); send(32'd3);
      send(32'd8);
      s_valid = 1'b1;
      s_data  = 32'd10;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check("t4_stall", 64'(s_ready), 64'(0));
      end
      tick();
      r_ready = 1'b1;
      @(negedge clock);
      check("t4_release", 64'(s_ready), 64'(1));
      tick();
      r_ready = 1'b0;
      s_valid = 1'b0;
      @(negedge clock);
      check("t4_r_valid", 64'(r_valid), 64'(1));
      check("t4_r_index", 64'(r_index), 64'(6));
      check("t4_r_data", 64'(r_data), 64'(9));
      tick();
      expect_result("t4a", 32'd2, 16'd5);

      // Stop mid-window keeps the pending result; start with stop stays idle.
      go(4);
      send(32'd1); send(32'd2);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      @(negedge clock);
      check("t5_busy", 64'(busy), 64'(0));
      check("t5_r_valid", 64'(r_valid), 64'(1));
      check("t5_r_index", 64'(r_index), 64'(6));
      tick();
      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      @(negedge clock);
      check("t5_start_stop_idle", 64'(busy), 64'(0));
      tick();
      r_ready = 1'b1;
      expect_result("t5", 32'd9, 16'd6);
      r_ready = 1'b0;

      // Asynchronous reset with a result pending.
      go(1);
      send(32'd11);
      @(posedge clock);
      #3 reset_n = 1'b0;
      #1;
      check("t6_r_valid", 64'(r_valid), 64'(0));
      check("t6_busy", 64'(busy), 64'(0));
      check("t6_dp_clear", 64'(dp_clear), 64'(1));
      tick();
      reset_n = 1'b1;
      got_d.delete(); got_i.delete();
      go(1);
      send(32'd50);
      r_ready = 1'b1;
      expect_result("t6", 32'd50, 16'd0);
      r_ready = 1'b0;

      // Randomised traffic checked cycle by cycle against the model.
      for (int c = 0; c < 3000; c++) begin
         s_valid = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 3))
            0:       s_data = $urandom;
            1:       s_data = 32'hFFFF_FFFF - $urandom_range(0, 3);
            2:       s_data = $urandom_range(0, 3);
            default: s_data = $urandom_range(0, 1000);
         endcase
         r_ready = ($urandom_range(0, 2) != 0);
         stop    = ($urandom_range(0, 99) == 0);
         start   = ($urandom_range(0, 7) == 0);
         win_len = 16'($urandom_range(0, 5));
         tick();
      end
      s_valid = 1'b0;
      start   = 1'b0;
      stop    = 1'b1;
      r_ready = 1'b1;
      repeat (4) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/minmax_window_seq.md
Name: minmax_window_seq

Overview:
- Sequencer for the min/max/average tracking datapath (clear/enable/reset control, 32-bit in/out).
- Takes a valid/ready sample stream, partitions it into windows of programmable length, and drives the datapath controls so min/max restart at each window boundary.
- Captures one average result per window into a one-deep output buffer with valid/ready handshake.
- Sits between the sample source and the result consumer; the datapath instance is external.

Parameters:
MSB, 31, index of data MSB (data width MSB+1)
CNTW, 16, width of window-length and window-index counters

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
start  input  1  begin windowed operation (level sampled in IDLE)
stop  input  1  abandon current window, return to IDLE
win_len  input  CNTW  samples per window, latched on start; 0 treated as 1
s_valid  input  1  sample available
s_ready  output  1  sample accepted when s_valid&&s_ready
s_data  input  MSB+1  sample value
dp_in  output  MSB+1  datapath data input
dp_clear  output  1  datapath clear
dp_enable  output  1  datapath enable
dp_reset  output  1  datapath reset; tied 0 (reserved)
dp_out  input  MSB+1  datapath combinational average output
r_valid  output  1  result buffer full
r_ready  input  1  consumer accepts result
r_data  output  MSB+1  window average
r_index  output  CNTW  window number of r_data, wraps at 2^CNTW
busy  output  1  state != IDLE

Behaviour:
- Reset: state=IDLE, r_valid=0, r_data=0, r_index=0, window counter=0, sample count=0, hold=0, first=1; busy=0, s_ready=0, dp_clear=1.
- States IDLE, CLR, RUN.
- IDLE: dp_clear=1, dp_enable=0, s_ready=0. start&&!stop -> CLR, latch win_len (0→1). stop wins over start.
- CLR (one cycle): dp_clear=1, s_ready=0, first:=1, count:=0 -> RUN.
- RUN, sample accepted: dp_clear=0, dp_enable=1, dp_in=s_data. hold:=dp_out, first:=0, count++.
- RUN, no sample, first=1: dp_enable=0 (datapath already cleared; harmless).
- RUN, no sample, first=0: dp_enable=1, dp_in=hold.
  - hold lies within [min,max], so min/max are unchanged.
  - This is mandatory: dropping enable would destroy the window.
- Last sample (count==len-1, accepted): r_data:=dp_out, r_index:=window counter, window counter++, r_valid:=1 -> CLR.
- s_ready = (state==RUN) && !(count==len-1 && r_valid && !r_ready).
  - Last sample stalls while the buffer is full and not draining.
  - Earlier samples never stall.
- r_valid clears on r_ready unless refilled the same cycle. Simultaneous drain+fill: new result loaded, r_valid stays 1.
- Result latency: r_valid rises the cycle after the last sample is accepted.
- Window throughput: len+1 cycles minimum (CLR bubble).
- stop in CLR/RUN: -> IDLE next cycle, partial window discarded, no result produced, pending r_valid/r_data retained until accepted. A sample accepted in the stop cycle is discarded.
- start outside IDLE ignored; win_len changes take effect only at next start.
- reset_n low at any time: immediate return to reset values, pending result lost.
- Averaging width (datapath-defined): avg = upper MSB+1 bits of (MSB+2)-bit sum max+min, i.e. floor, no overflow.

Decomposition:
- Shared package: state encoding (IDLE/CLR/RUN), default MSB/CNTW constants, the all-ones/zero datapath init constants.
- One natural sub-module: minmax_result_buf (one-deep valid/ready register holding r_data/r_index).
- FSM and counters stay in the top.

Test Plan:
- win_len=4, samples 10,20,30,40 back-to-back -> r_data=25, r_index=0, r_valid 1 cycle after 4th accept.
- win_len=2, samples 5, three idle cycles, 7 -> r_data=6; datapath min/max unchanged during gaps (dp_in=hold=5).
- win_len=1, sample 100 -> r_data=100; next window 0xFFFFFFFF then win_len=2 second window 0xFFFFFFFF,0xFFFFFFFE -> r_data=0xFFFFFFFE (no overflow).
- win_len=2, r_ready=0: first window result held; second window's 2nd sample sees s_ready=0 until r_ready pulses; drain+fill same cycle keeps r_valid=1, r_index=1.
- stop after 2 of 4 samples -> IDLE, no new result, earlier pending result still valid; start+stop together in IDLE -> stays IDLE.
- reset_n asserted mid-RUN with r_valid=1 -> r_valid=0, busy=0, dp_clear=1 asynchronously; restart yields r_index=0.
